// File: rtl/seg7_scan_ctrl_if.sv
// Register-bus port of the 7-segment scan controller: one select, write enable,
// 2-bit word address, 16-bit write data and registered 16-bit read data.
interface seg7_scan_ctrl_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment display controller with PWM brightness and
// frame-synchronous shadowing of the digit value, decimal-point and blank masks.
module seg7_scan_ctrl #(
    parameter int TICK_DIV = 3125
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   bus,
    output logic [6:0]        segments,
    output logic              decimal_point,
    output logic [3:0]        anode,
    output logic              frame_tick
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [15:0]      r_value;
    logic [3:0]       r_dp;
    logic [3:0]       r_blank;
    logic             r_en;
    logic [3:0]       r_duty;
    logic [15:0]      r_rdata;

    logic [PRE_W-1:0] r_pre;
    logic [3:0]       r_pwm;
    logic [1:0]       r_dig;

    logic [15:0]      r_sh_value;
    logic [3:0]       r_sh_dp;
    logic [3:0]       r_sh_blank;

    logic [6:0]       r_segments;
    logic             r_decimal_point;
    logic [3:0]       r_anode;
    logic             r_frame_tick;

    logic             w_wr;
    logic             w_rd;
    logic             w_pre_wrap;
    logic             w_frame_wrap;
    logic             w_on;
    logic [15:0]      w_rd_mux;
    logic [3:0]       w_nib [4];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_wr         = bus.sel && bus.we;
    assign w_rd         = bus.sel && !bus.we;
    assign w_pre_wrap   = (r_pre == PRE_LAST);
    assign w_frame_wrap = w_pre_wrap && (r_pwm == 4'hF) && (r_dig == 2'd3);

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign w_nib[gi] = r_sh_value[4*gi +: 4];
    end

    // EN and DUTY come straight from the live registers; only digit content is shadowed.
    assign w_on = r_en && !r_sh_blank[r_dig] && (r_pwm <= r_duty);

    always_comb begin
        w_rd_mux = 16'h0000;
        case (bus.addr)
            2'd0: w_rd_mux = r_value;
            2'd1: w_rd_mux = {12'h000, r_dp};
            2'd2: w_rd_mux = {12'h000, r_blank};
            2'd3: w_rd_mux = {8'h00, r_duty, 3'b000, r_en};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= 16'h0000;
            r_dp    <= 4'h0;
            r_blank <= 4'h0;
            r_en    <= 1'b1;
            r_duty  <= 4'hF;
            r_rdata <= 16'h0000;
        end else begin
            if (w_wr) begin
                case (bus.addr)
                    2'd0: r_value <= bus.wdata;
                    2'd1: r_dp    <= bus.wdata[3:0];
                    2'd2: r_blank <= bus.wdata[3:0];
                    2'd3: begin
                        r_en   <= bus.wdata[0];
                        r_duty <= bus.wdata[7:4];
                    end
                endcase
            end
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
            r_pwm <= 4'h0;
            r_dig <= 2'd0;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            r_pwm <= r_pwm + 4'd1;
            if (r_pwm == 4'hF) begin
                r_dig <= r_dig + 2'd1;
            end
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Capture uses the pre-edge register values, so a write on the wrap edge waits a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_value <= 16'h0000;
            r_sh_dp    <= 4'h0;
            r_sh_blank <= 4'h0;
        end else if (w_frame_wrap) begin
            r_sh_value <= r_value;
            r_sh_dp    <= r_dp;
            r_sh_blank <= r_blank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode         <= 4'hF;
            r_segments      <= 7'h7F;
            r_decimal_point <= 1'b1;
            r_frame_tick    <= 1'b0;
        end else begin
            r_anode         <= w_on ? ~(4'b0001 << r_dig) : 4'hF;
            r_segments      <= w_on ? hex7(w_nib[r_dig]) : 7'h7F;
            r_decimal_point <= w_on ? ~r_sh_dp[r_dig] : 1'b1;
            r_frame_tick    <= w_frame_wrap;
        end
    end

    assign bus.rdata     = r_rdata;
    assign anode         = r_anode;
    assign segments      = r_segments;
    assign decimal_point = r_decimal_point;
    assign frame_tick    = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with TICK_DIV=2 (32-cycle slots, 128-cycle frames).
module tb_seg7_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] segments;
    logic       decimal_point;
    logic [3:0] anode;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = -1;

    // Active-low anode per digit index, and the 7-seg codes for 0x1234 (digit 0 = '4').
    logic [3:0] AN_TAB   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] SEG_1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    seg7_scan_ctrl_if bus_if ();

    seg7_scan_ctrl #(.TICK_DIV(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .segments      (segments),
        .decimal_point (decimal_point),
        .anode         (anode),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_if.sel   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        tick();
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        $display("cyc=%0d write addr=%0d data=%h", cyc, a, d);
    endtask

    task automatic bus_read(input logic [1:0] a);
        bus_if.sel  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        tick();
        bus_if.sel  = 1'b0;
        $display("cyc=%0d read addr=%0d rdata=%h", cyc, a, bus_if.rdata);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (anode !== 4'b1111) begin failures++; $display("FAIL reset_anode got=%b exp=1111", anode); end
        checks++; if (segments !== 7'h7F) begin failures++; $display("FAIL reset_segments got=%b exp=1111111", segments); end
        checks++; if (decimal_point !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", decimal_point); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        checks++; if (bus_if.rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus_if.rdata); end
        reset = 1'b0;
        cyc = -1;
    endtask

    task automatic test_scan();
        logic exp_ft;
        for (int i = 0; i < 128; i++) begin
            tick();
            exp_ft = ((cyc % 128) == 127);
            checks++; if (anode !== AN_TAB[(cyc/32)%4]) begin failures++; $display("FAIL scan_anode cyc=%0d got=%b exp=%b", cyc, anode, AN_TAB[(cyc/32)%4]); end
            checks++; if (frame_tick !== exp_ft) begin failures++; $display("FAIL scan_frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_ft); end
            checks++; if (segments !== SEG_ZERO) begin failures++; $display("FAIL scan_segments cyc=%0d got=%b exp=%b", cyc, segments, SEG_ZERO); end
        end
        $display("scan frame done cyc=%0d", cyc);
    endtask

    task automatic test_value_shadow();
        int d;
        logic exp_ft;
        while (cyc < 149) tick();
        bus_write(2'd0, 16'h1234);
        while (cyc < 255) begin
            tick();
            exp_ft = ((cyc % 128) == 127);
            checks++; if (segments !== SEG_ZERO) begin failures++; $display("FAIL value_hold cyc=%0d got=%b exp=%b", cyc, segments, SEG_ZERO); end
            checks++; if (frame_tick !== exp_ft) begin failures++; $display("FAIL value_frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_ft); end
        end
        while (cyc < 383) begin
            tick();
            d = (cyc / 32) % 4;
            checks++; if (segments !== SEG_1234[d]) begin failures++; $display("FAIL value_segments cyc=%0d got=%b exp=%b", cyc, segments, SEG_1234[d]); end
            checks++; if (anode !== AN_TAB[d]) begin failures++; $display("FAIL value_anode cyc=%0d got=%b exp=%b", cyc, anode, AN_TAB[d]); end
        end
        $display("value frame done cyc=%0d", cyc);
    endtask

    task automatic test_dp_blank();
        int d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        bus_write(2'd1, 16'h0005);
        bus_write(2'd2, 16'h0002);
        while (cyc < 511) begin
            tick();
            d = (cyc / 32) % 4;
            checks++; if (decimal_point !== 1'b1) begin failures++; $display("FAIL dp_shadowed cyc=%0d got=%b exp=1", cyc, decimal_point); end
            checks++; if (anode !== AN_TAB[d]) begin failures++; $display("FAIL blank_shadowed cyc=%0d got=%b exp=%b", cyc, anode, AN_TAB[d]); end
        end
        while (cyc < 639) begin
            tick();
            d = (cyc / 32) % 4;
            if (d == 1) begin
                exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = AN_TAB[d]; exp_seg = SEG_1234[d]; exp_dp = (d == 0 || d == 2) ? 1'b0 : 1'b1;
            end
            checks++; if (anode !== exp_an) begin failures++; $display("FAIL blank_anode cyc=%0d got=%b exp=%b", cyc, anode, exp_an); end
            checks++; if (segments !== exp_seg) begin failures++; $display("FAIL blank_segments cyc=%0d got=%b exp=%b", cyc, segments, exp_seg); end
            checks++; if (decimal_point !== exp_dp) begin failures++; $display("FAIL dp_point cyc=%0d got=%b exp=%b", cyc, decimal_point, exp_dp); end
        end
        $display("dp/blank frame done cyc=%0d", cyc);
    endtask

    task automatic test_duty();
        int d;
        int active;
        logic lit;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        // DUTY=3: lit for pwm 0..3 (first 8 cycles of each slot) on digits 2 and 3.
        bus_write(2'd3, 16'h0031);
        while (cyc < 703) tick();
        active = 0;
        while (cyc < 767) begin
            tick();
            d = (cyc / 32) % 4;
            lit = ((cyc % 32) < 8);
            exp_an  = lit ? AN_TAB[d] : 4'b1111;
            exp_seg = lit ? SEG_1234[d] : 7'h7F;
            exp_dp  = lit ? ((d == 2) ? 1'b0 : 1'b1) : 1'b1;
            if (anode !== 4'b1111) active++;
            checks++; if (anode !== exp_an) begin failures++; $display("FAIL duty3_anode cyc=%0d got=%b exp=%b", cyc, anode, exp_an); end
            checks++; if (segments !== exp_seg) begin failures++; $display("FAIL duty3_segments cyc=%0d got=%b exp=%b", cyc, segments, exp_seg); end
            checks++; if (decimal_point !== exp_dp) begin failures++; $display("FAIL duty3_dp cyc=%0d got=%b exp=%b", cyc, decimal_point, exp_dp); end
            if ((cyc % 32) == 31) begin
                checks++; if (active !== 8) begin failures++; $display("FAIL duty3_count cyc=%0d got=%0d exp=8", cyc, active); end
                active = 0;
            end
        end
        // DUTY=0: lit for pwm 0 only (2 cycles per slot).
        bus_write(2'd3, 16'h0001);
        while (cyc < 831) tick();
        active = 0;
        while (cyc < 895) begin
            tick();
            d = (cyc / 32) % 4;
            lit = ((cyc % 32) < 2);
            exp_an = lit ? AN_TAB[d] : 4'b1111;
            if (anode !== 4'b1111) active++;
            checks++; if (anode !== exp_an) begin failures++; $display("FAIL duty0_anode cyc=%0d got=%b exp=%b", cyc, anode, exp_an); end
            if ((cyc % 32) == 31) begin
                checks++; if (active !== 2) begin failures++; $display("FAIL duty0_count cyc=%0d got=%0d exp=2", cyc, active); end
                active = 0;
            end
        end
        $display("duty tests done cyc=%0d", cyc);
    endtask

    task automatic test_enable();
        logic exp_ft;
        bus_write(2'd3, 16'h00F0);
        while (cyc < 1023) begin
            tick();
            exp_ft = ((cyc % 128) == 127);
            checks++; if (anode !== 4'b1111) begin failures++; $display("FAIL en_anode cyc=%0d got=%b exp=1111", cyc, anode); end
            checks++; if (segments !== 7'h7F) begin failures++; $display("FAIL en_segments cyc=%0d got=%b exp=1111111", cyc, segments); end
            checks++; if (decimal_point !== 1'b1) begin failures++; $display("FAIL en_dp cyc=%0d got=%b exp=1", cyc, decimal_point); end
            checks++; if (frame_tick !== exp_ft) begin failures++; $display("FAIL en_frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_ft); end
        end
        $display("enable test done cyc=%0d", cyc);
    endtask

    task automatic test_read();
        bus_write(2'd0, 16'h1234);
        bus_read(2'd0);
        checks++; if (bus_if.rdata !== 16'h1234) begin failures++; $display("FAIL read_value got=%h exp=1234", bus_if.rdata); end
        tick();
        checks++; if (bus_if.rdata !== 16'h1234) begin failures++; $display("FAIL read_hold got=%h exp=1234", bus_if.rdata); end
        bus_write(2'd1, 16'h0005);
        bus_read(2'd1);
        checks++; if (bus_if.rdata !== 16'h0005) begin failures++; $display("FAIL read_dp got=%h exp=0005", bus_if.rdata); end
        bus_write(2'd2, 16'h0002);
        bus_read(2'd2);
        checks++; if (bus_if.rdata !== 16'h0002) begin failures++; $display("FAIL read_blank got=%h exp=0002", bus_if.rdata); end
        bus_write(2'd3, 16'hABF3);
        bus_read(2'd3);
        checks++; if (bus_if.rdata !== 16'h00F1) begin failures++; $display("FAIL read_ctrl_mask got=%h exp=00f1", bus_if.rdata); end
        bus_write(2'd3, 16'h0031);
        bus_read(2'd3);
        checks++; if (bus_if.rdata !== 16'h0031) begin failures++; $display("FAIL read_ctrl got=%h exp=0031", bus_if.rdata); end
    endtask

    task automatic test_reset_mid();
        while ((cyc % 128) != 74) tick();
        reset = 1'b1;
        tick();
        checks++; if (anode !== 4'b1111) begin failures++; $display("FAIL midrst_anode got=%b exp=1111", anode); end
        checks++; if (segments !== 7'h7F) begin failures++; $display("FAIL midrst_segments got=%b exp=1111111", segments); end
        checks++; if (decimal_point !== 1'b1) begin failures++; $display("FAIL midrst_dp got=%b exp=1", decimal_point); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL midrst_frame_tick got=%b exp=0", frame_tick); end
        checks++; if (bus_if.rdata !== 16'h0000) begin failures++; $display("FAIL midrst_rdata got=%h exp=0000", bus_if.rdata); end
        reset = 1'b0;
        cyc = -1;
        tick();
        checks++; if (anode !== 4'b1110) begin failures++; $display("FAIL midrst_restart_anode got=%b exp=1110", anode); end
        checks++; if (segments !== SEG_ZERO) begin failures++; $display("FAIL midrst_restart_segments got=%b exp=%b", segments, SEG_ZERO); end
        while (cyc < 32) tick();
        checks++; if (anode !== 4'b1101) begin failures++; $display("FAIL midrst_slot1_anode got=%b exp=1101", anode); end
        bus_read(2'd0);
        checks++; if (bus_if.rdata !== 16'h0000) begin failures++; $display("FAIL midrst_value got=%h exp=0000", bus_if.rdata); end
        bus_read(2'd1);
        checks++; if (bus_if.rdata !== 16'h0000) begin failures++; $display("FAIL midrst_dpreg got=%h exp=0000", bus_if.rdata); end
        bus_read(2'd2);
        checks++; if (bus_if.rdata !== 16'h0000) begin failures++; $display("FAIL midrst_blank got=%h exp=0000", bus_if.rdata); end
        bus_read(2'd3);
        checks++; if (bus_if.rdata !== 16'h00F1) begin failures++; $display("FAIL midrst_ctrl got=%h exp=00f1", bus_if.rdata); end
    endtask

    initial begin
        reset        = 1'b1;
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 2'd0;
        bus_if.wdata = 16'h0000;
        test_reset();
        test_scan();
        test_value_shadow();
        test_dp_blank();
        test_duty();
        test_enable();
        test_read();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
